// File: rtl/ws2811_frame_seq_if.sv
// Write/control port between the frame sequencer (master) and the WS2811 string driver (slave).
interface ws2811_frame_seq_if;
    logic        wr;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        bank;
    logic [7:0]  leds;
    logic        start;

    modport master (output wr, wr_addr, wr_data, bank, leds, start);
    modport slave  (input  wr, wr_addr, wr_data, bank, leds, start);
endinterface

// File: rtl/ws2811_frame_seq.sv
// Ping-pong frame sequencer for the 128-pixel WS2811 driver: renders solid/chase/gradient frames.
// Define FRAME_SEQ_BRIGHTNESS_EN to enable global brightness scaling in pipeline stage 2.
module ws2811_frame_seq #(
    parameter int DIV_W    = 24,
    parameter int MAX_LEDS = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DIV_W-1:0]   frame_div,
    input  logic [7:0]         num_leds,
    input  logic [1:0]         mode,
    input  logic [23:0]        color,
    input  logic [7:0]         brightness,
    ws2811_frame_seq_if.master drv,
    output logic               busy,
    output logic [7:0]         overrun
);

    typedef enum logic [2:0] {IDLE, FILL, DRAIN, FLIP, START} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] timer;
    logic             tick;
    logic [7:0]       n_clamp, n_r, chase_pos, chase_lit;
    logic [1:0]       mode_r;
    logic [23:0]      color_r;
    logic             fill_bank, bank_r, drain_cnt, last_idx;
    logic [6:0]       idx;
    logic [7:0]       leds_r;
    logic [7:0]       grad_r;
    logic [23:0]      pix;
    logic             s1_valid, wr_r;
    logic [7:0]       s1_addr, wr_addr_r;
    logic [23:0]      s1_color, wr_data_r;

    assign tick      = enable && (frame_div != '0) && (timer == frame_div);
    assign n_clamp   = (num_leds > 8'(MAX_LEDS)) ? 8'(MAX_LEDS) : num_leds;
    assign last_idx  = ({1'b0, idx} == (n_r - 8'd1));
    assign chase_lit = (chase_pos >= n_r) ? 8'd0 : chase_pos;
    assign busy      = (state != IDLE);

    assign drv.wr      = wr_r;
    assign drv.wr_addr = wr_addr_r;
    assign drv.wr_data = wr_data_r;
    assign drv.bank    = bank_r;
    assign drv.leds    = leds_r;
    assign drv.start   = (state == START);

    always_ff @(posedge clk) begin
        if (rst || !enable || (frame_div == '0) || (timer == frame_div))
            timer <= '0;
        else
            timer <= timer + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick && (n_clamp != 8'd0)) state_nxt = FILL;
            FILL:    if (last_idx) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = FLIP;
            FLIP:    state_nxt = START;
            START:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame parameters are captured only on an accepted tick so busy-time input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r       <= 8'd0;
            mode_r    <= 2'd0;
            color_r   <= 24'd0;
            fill_bank <= 1'b0;
            bank_r    <= 1'b0;
            leds_r    <= 8'd0;
            idx       <= 7'd0;
            drain_cnt <= 1'b0;
            chase_pos <= 8'd0;
            overrun   <= 8'd0;
        end else begin
            if (tick && (state != IDLE) && (overrun != 8'hFF))
                overrun <= overrun + 8'd1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        n_r       <= n_clamp;
                        mode_r    <= mode;
                        color_r   <= color;
                        fill_bank <= ~bank_r;
                        idx       <= 7'd0;
                        drain_cnt <= 1'b0;
                    end
                end
                FILL:  idx <= idx + 7'd1;
                DRAIN: drain_cnt <= ~drain_cnt;
                FLIP: begin
                    bank_r <= fill_bank;
                    leds_r <= n_r;
                end
                START: begin
                    if (({1'b0, chase_pos} + 9'd1) >= {1'b0, n_r})
                        chase_pos <= 8'd0;
                    else
                        chase_pos <= chase_pos + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign grad_r = {idx, 1'b0};

    always_comb begin
        pix = color_r;
        case (mode_r)
            2'd1:    pix = ({1'b0, idx} == chase_lit) ? color_r : 24'd0;
            2'd2:    pix = {grad_r, color_r[15:8], ~grad_r};
            default: pix = color_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= 8'd0;
            s1_color <= 24'd0;
        end else begin
            s1_valid <= (state == FILL);
            s1_addr  <= {fill_bank, idx};
            s1_color <= pix;
        end
    end

`ifdef FRAME_SEQ_BRIGHTNESS_EN
    logic [7:0] bright_r;
    logic [8:0] scale_k;

    assign scale_k = {1'b0, bright_r} + 9'd1;

    // (ch * (brightness+1)) >> 8 makes 255 an exact identity and 0 fully dark.
    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [8:0] k);
        return 8'(({8'd0, ch} * {7'd0, k}) >> 8);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            bright_r <= 8'd0;
        else if ((state == IDLE) && tick)
            bright_r <= brightness;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r      <= 1'b0;
            wr_addr_r <= 8'd0;
            wr_data_r <= 24'd0;
        end else begin
            wr_r <= s1_valid;
            if (s1_valid) begin
                wr_addr_r <= s1_addr;
                wr_data_r <= {scale_ch(s1_color[23:16], scale_k),
                              scale_ch(s1_color[15:8],  scale_k),
                              scale_ch(s1_color[7:0],   scale_k)};
            end
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r      <= 1'b0;
            wr_addr_r <= 8'd0;
            wr_data_r <= 24'd0;
        end else begin
            wr_r <= s1_valid;
            if (s1_valid) begin
                wr_addr_r <= s1_addr;
                wr_data_r <= s1_color;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ws2811_frame_seq.sv
// Directed self-checking bench for ws2811_frame_seq; expectations follow FRAME_SEQ_BRIGHTNESS_EN.
module tb_ws2811_frame_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] frame_div = '0;
    logic [7:0]  num_leds = '0;
    logic [1:0]  mode = '0;
    logic [23:0] color = '0;
    logic [7:0]  brightness = '0;
    logic        busy;
    logic [7:0]  overrun;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int start_long = 0;
    logic prev_start = 1'b0;
    logic [7:0]  wa_q[$];
    logic [23:0] wd_q[$];

    always #5 clk = ~clk;

    ws2811_frame_seq_if bus();

    ws2811_frame_seq #(.DIV_W(24), .MAX_LEDS(128)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_div(frame_div),
        .num_leds(num_leds), .mode(mode), .color(color), .brightness(brightness),
        .drv(bus), .busy(busy), .overrun(overrun)
    );

    // Records every write strobe and watches that start never stays high two cycles running.
    always @(negedge clk) begin
        if (bus.wr) begin
            wa_q.push_back(bus.wr_addr);
            wd_q.push_back(bus.wr_data);
        end
        if (bus.start) start_cnt++;
        if (bus.start && prev_start) start_long++;
        prev_start = bus.start;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] m, input logic [23:0] c, input logic [7:0] n,
                                  input logic [7:0] b, input logic [23:0] fd);
        mode = m; color = c; num_leds = n; brightness = b; frame_div = fd;
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return bus.start;
            1:       return busy;
            default: return bus.wr;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int budget);
        int k = 0;
        @(negedge clk);
        while (!probe(which) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output({tag, "_wait"}, {31'd0, probe(which)}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_wr"},      {31'd0, bus.wr},    32'd0);
        check_output({tag, "_wr_addr"}, {24'd0, bus.wr_addr}, 32'd0);
        check_output({tag, "_wr_data"}, {8'd0, bus.wr_data}, 32'd0);
        check_output({tag, "_bank"},    {31'd0, bus.bank},  32'd0);
        check_output({tag, "_leds"},    {24'd0, bus.leds},  32'd0);
        check_output({tag, "_start"},   {31'd0, bus.start}, 32'd0);
        check_output({tag, "_busy"},    {31'd0, busy},      32'd0);
        check_output({tag, "_overrun"}, {24'd0, overrun},   32'd0);
    endtask

    task automatic run_frame(input string tag, input int budget);
        wa_q.delete();
        wd_q.delete();
        enable = 1'b1;
        wait_for(tag, 0, budget);
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] exp_b127;
        logic [23:0] exp_b0;
        logic [7:0]  gr;
        int          sc;
`ifdef FRAME_SEQ_BRIGHTNESS_EN
        exp_b127 = 24'h7F4000;
        exp_b0   = 24'h000000;
`else
        exp_b127 = 24'hFF8001;
        exp_b0   = 24'hFF8001;
`endif

        // Reset state
        do_reset();
        check_reset("reset");

        // Basic solid frame: first tick lands 100 cycles after enable
        apply_stimulus(2'd0, 24'h102030, 8'd3, 8'd255, 24'd99);
        wa_q.delete(); wd_q.delete();
        enable = 1'b1;
        repeat (99) @(negedge clk);
        check_output("solid_idle_before_tick", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_output("solid_busy_after_tick", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        check_output("solid_first_wr", {31'd0, bus.wr}, 32'd1);
        check_output("solid_first_addr", {24'd0, bus.wr_addr}, 32'h80);
        wait_for("solid1", 0, 20);
        check_output("solid1_bank", {31'd0, bus.bank}, 32'd1);
        check_output("solid1_leds", {24'd0, bus.leds}, 32'd3);
        check_output("solid1_count", wa_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            check_output($sformatf("solid1_addr%0d", i), {24'd0, wa_q[i]}, 32'h80 + i);
            check_output($sformatf("solid1_data%0d", i), {8'd0, wd_q[i]}, 32'h102030);
        end
        wa_q.delete(); wd_q.delete();
        @(negedge clk);
        check_output("solid1_start_one_cycle", {31'd0, bus.start}, 32'd0);
        wait_for("solid2", 0, 150);
        check_output("solid2_bank", {31'd0, bus.bank}, 32'd0);
        check_output("solid2_count", wa_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < wa_q.size(); i++)
            check_output($sformatf("solid2_addr%0d", i), {24'd0, wa_q[i]}, i);
        enable = 1'b0;

        // Chase over five frames, lit pixel walks 0,1,2,3 then wraps
        do_reset();
        apply_stimulus(2'd1, 24'hFF0000, 8'd4, 8'd255, 24'd19);
        wa_q.delete(); wd_q.delete();
        enable = 1'b1;
        for (int f = 0; f < 5; f++) begin
            wait_for($sformatf("chase%0d", f), 0, 40);
            check_output($sformatf("chase%0d_bank", f), {31'd0, bus.bank}, (f % 2 == 0) ? 32'd1 : 32'd0);
            check_output($sformatf("chase%0d_count", f), wa_q.size(), 32'd4);
            for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
                check_output($sformatf("chase%0d_addr%0d", f, i), {24'd0, wa_q[i]},
                             ((f % 2 == 0) ? 32'h80 : 32'h00) + i);
                check_output($sformatf("chase%0d_data%0d", f, i), {8'd0, wd_q[i]},
                             (i == f % 4) ? 32'hFF0000 : 32'h0);
            end
            wa_q.delete(); wd_q.delete();
        end
        enable = 1'b0;
        @(negedge clk);
        check_output("chase_no_overrun", {24'd0, overrun}, 32'd0);

        // Brightness scaling
        apply_stimulus(2'd0, 24'hFF8001, 8'd1, 8'd127, 24'd9);
        run_frame("bri127", 30);
        check_output("bri127_count", wa_q.size(), 32'd1);
        check_output("bri127_addr", {24'd0, wa_q[0]}, 32'h00);
        check_output("bri127_data", {8'd0, wd_q[0]}, {8'd0, exp_b127});
        apply_stimulus(2'd0, 24'hFF8001, 8'd1, 8'd0, 24'd9);
        run_frame("bri0", 30);
        check_output("bri0_count", wa_q.size(), 32'd1);
        check_output("bri0_addr", {24'd0, wa_q[0]}, 32'h80);
        check_output("bri0_data", {8'd0, wd_q[0]}, {8'd0, exp_b0});

        // Gradient with inputs changed mid-frame (must be ignored)
        apply_stimulus(2'd2, 24'h135579, 8'd3, 8'd255, 24'd9);
        wa_q.delete(); wd_q.delete();
        enable = 1'b1;
        wait_for("grad_busy", 1, 30);
        apply_stimulus(2'd0, 24'h000000, 8'd1, 8'd0, 24'd9);
        wait_for("grad", 0, 30);
        enable = 1'b0;
        @(negedge clk);
        check_output("grad_leds", {24'd0, bus.leds}, 32'd3);
        check_output("grad_bank", {31'd0, bus.bank}, 32'd0);
        check_output("grad_count", wa_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            gr = 8'(2 * i);
            check_output($sformatf("grad_addr%0d", i), {24'd0, wa_q[i]}, i);
            check_output($sformatf("grad_data%0d", i), {8'd0, wd_q[i]}, {8'd0, gr, 8'h55, ~gr});
        end

        // Clamp: 200 requested, 128 written
        apply_stimulus(2'd0, 24'h010203, 8'd200, 8'd255, 24'd199);
        run_frame("clamp", 400);
        check_output("clamp_count", wa_q.size(), 32'd128);
        check_output("clamp_leds", {24'd0, bus.leds}, 32'd128);
        check_output("clamp_bank", {31'd0, bus.bank}, 32'd1);
        for (int i = 0; i < 128 && i < wa_q.size(); i++)
            check_output($sformatf("clamp_addr%0d", i), {24'd0, wa_q[i]}, 32'h80 + i);
        check_output("clamp_last_data", {8'd0, wd_q[wd_q.size()-1]}, 32'h010203);

        // Skip: zero LEDs produces nothing
        apply_stimulus(2'd0, 24'hABCDEF, 8'd0, 8'd255, 24'd9);
        wa_q.delete(); wd_q.delete();
        sc = start_cnt;
        enable = 1'b1;
        repeat (35) @(negedge clk);
        check_output("skip_no_wr", wa_q.size(), 32'd0);
        check_output("skip_no_start", start_cnt, sc);
        check_output("skip_bank", {31'd0, bus.bank}, 32'd1);
        check_output("skip_leds", {24'd0, bus.leds}, 32'd128);
        check_output("skip_busy", {31'd0, busy}, 32'd0);
        enable = 1'b0;

        // Overrun: 11-cycle ticks against 132-cycle busy frames, 12 drops per frame
        do_reset();
        apply_stimulus(2'd0, 24'h112233, 8'd128, 8'd255, 24'd10);
        wa_q.delete(); wd_q.delete();
        enable = 1'b1;
        wait_for("ovr1", 0, 200);
        check_output("ovr1_at_start", {24'd0, overrun}, 32'd11);
        @(negedge clk);
        check_output("ovr1_after_start", {24'd0, overrun}, 32'd12);
        check_output("ovr1_count", wa_q.size(), 32'd128);
        wa_q.delete(); wd_q.delete();
        wait_for("ovr2", 0, 200);
        check_output("ovr2_at_start", {24'd0, overrun}, 32'd23);
        @(negedge clk);
        check_output("ovr2_after_start", {24'd0, overrun}, 32'd24);
        check_output("ovr2_count", wa_q.size(), 32'd128);
        check_output("start_never_long", start_long, 32'd0);

        // Reset in the middle of FILL at index 50
        wait_for("mid_busy", 1, 50);
        repeat (50) @(negedge clk);
        check_output("mid_wr_before_reset", {31'd0, bus.wr}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        rst = 1'b0;
        wa_q.delete(); wd_q.delete();
        wait_for("post_reset_wr", 2, 50);
        check_output("post_reset_addr", {24'd0, bus.wr_addr}, 32'h80);
        check_output("post_reset_data", {8'd0, bus.wr_data}, 32'h112233);
        wait_for("post_reset", 0, 200);
        check_output("post_reset_count", wa_q.size(), 32'd128);
        check_output("post_reset_bank", {31'd0, bus.bank}, 32'd1);
        enable = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
